l2_request_arbiter: RTL and testbench
=====================================

Name: l2_request_arbiter

Overview:
Shares the single unified L2 cache port between the L1I miss path and the L1D miss/writeback path.
- Accepts one line-sized read request from L1I and one read or write request from L1D.
- Selects one with a fixed-priority or round-robin policy, then latches and holds that transaction on the L2 port until resp_l2.
- Routes the response back to the granted requester.
- Emits a one-cycle id_conflict pulse when both sides request in the same arbitration cycle; the performance counter unit increments ID_conf on this pulse.

Parameters:
ADDR_WIDTH, 32, address width of all ports
LINE_WIDTH, 256, cache line data width
FAIR, 1, 1 = round-robin on conflict; 0 = L1D always wins

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
read_I  input  1  L1I line read request, held until resp_I
address_I  input  ADDR_WIDTH  L1I line address
rdata_I  output  LINE_WIDTH  line returned to L1I
resp_I  output  1  L1I completion pulse
read_D  input  1  L1D line read request, held until resp_D
write_D  input  1  L1D writeback request, held until resp_D
address_D  input  ADDR_WIDTH  L1D line address
wdata_D  input  LINE_WIDTH  L1D writeback line
rdata_D  output  LINE_WIDTH  line returned to L1D
resp_D  output  1  L1D completion pulse
read_l2  output  1  L2 read strobe
write_l2  output  1  L2 write strobe
address_l2  output  ADDR_WIDTH  L2 address
wdata_l2  output  LINE_WIDTH  L2 write data
rdata_l2  input  LINE_WIDTH  L2 read data
resp_l2  input  1  L2 completion pulse
id_conflict  output  1  pulse: both sides requested in the same arbitration cycle

Behaviour:
- FSM states: IDLE, GRANT_I, GRANT_D.
- Internal registers:
  - cmd_rd, cmd_wr, cmd_addr, cmd_wdata: latched L2 command.
  - last_grant: 0 = I, 1 = D.
- Definitions: reqI = read_I; reqD = read_D | write_D.
- IDLE:
  - If only reqI is set: latch read, address_I; go to GRANT_I.
  - If only reqD is set: latch the D command; go to GRANT_D.
  - If both are set: id_conflict = 1 this cycle (combinational).
    - FAIR=0: D wins.
    - FAIR=1: grant the side opposite last_grant.
  - last_grant updates on every grant.
- D-side command: write_D takes precedence if read_D and write_D are both high, so cmd_wr = 1 and cmd_rd = 0. wdata_D is latched only on a write.
- GRANT_x:
  - read_l2 and write_l2 = cmd_rd and cmd_wr; address_l2 = cmd_addr; wdata_l2 = cmd_wdata.
  - All are driven from the latched registers, never from live inputs.
  - On resp_l2: resp_x = 1 and rdata_x = rdata_l2 in the same cycle (combinational pass-through, zero added latency). Next state is IDLE.
- Dead cycle: IDLE after every completion gives one cycle with no L2 strobes, so the just-served requester can deassert and is not re-granted.
- Minimum arbitration latency: request at cycle n, L2 strobe at n+1, resp_x in the same cycle as resp_l2.
- A requester that deasserts mid-grant does not abort the transaction. The FSM waits for resp_l2 and still pulses resp_x once.
- resp_l2 while in IDLE is ignored (no resp_I or resp_D).
- Outputs when not granted: read_l2 = write_l2 = resp_I = resp_D = 0. address_l2, wdata_l2, rdata_I and rdata_D are 0 outside their active use.
- Reset (including mid-transaction): FSM to IDLE, all cmd_* registers 0, last_grant = 0 (so the first FAIR conflict goes to D), all outputs 0 in the following cycle. Any in-flight L2 response is dropped.
- id_conflict is asserted only in IDLE, at most once per arbitration.

Decomposition:
- Shared package (cache_types_pkg): enum arb_state_t {IDLE, GRANT_I, GRANT_D}; localparams for line and address widths, shared with the L1/L2 caches.
- Sub-module arb_priority_select (combinational): inputs reqI, reqD, last_grant, FAIR; outputs grant_I, grant_D, conflict.
- The top-level module holds the FSM, command latch and response routing.

Test Plan:
- Sole I: read_I=1, address_I=0x0000_0040; L2 responds 3 cycles after strobe with rdata_l2=0xA5…A5 -> read_l2=1 with address_l2=0x40 from cycle 1; resp_I=1 and rdata_I=0xA5…A5 in the resp_l2 cycle; resp_D never asserts.
- Conflict with FAIR=1 after reset: read_I and write_D asserted together -> id_conflict=1 for one cycle; D granted first (write_l2=1, wdata_l2=wdata_D); after resp_D and one dead IDLE cycle, I granted; a second simultaneous pair again pulses id_conflict and grants D second only if I was last.
- FAIR=0: I and D requesting continuously for 4 transactions -> D granted every time; id_conflict pulses 4 times.
- Command latching: change address_D from 0x100 to 0x200 mid-grant -> address_l2 stays 0x100 until resp_l2.
- Reset mid-grant: assert reset 2 cycles into GRANT_I -> next cycle read_l2=0 and state IDLE; a late resp_l2 produces no resp_I.
- read_D and write_D both high -> write_l2=1, read_l2=0; resp_l2 while idle -> no responses.

Source files
------------

// File: rtl/cache_types_pkg.sv
// Shared cache types: arbiter FSM state encoding and default address/line widths
// used by the L1 caches, the L2 cache and the L2 request arbiter.
package cache_types_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  // Encoding of the last_grant register: which side was served most recently.
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

endpackage

// File: rtl/arb_priority_select.sv
// Combinational winner selection between the L1I and L1D request lines.
// With FAIR set, a simultaneous request goes to the side that was not served
// last; with FAIR clear, L1D always wins a tie.
module arb_priority_select
  import cache_types_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic grant_i,
  output logic grant_d,
  output logic conflict
);

  logic d_wins_tie;

  // Decide who wins a tie, then resolve the single-requester cases around it.
  always_comb begin
    d_wins_tie = 1'b1;
    if (FAIR) begin
      d_wins_tie = (last_grant == LAST_I);
    end
    conflict = req_i & req_d;
    grant_d  = req_d & (~req_i | d_wins_tie);
    grant_i  = req_i & ~grant_d;
  end

endmodule

// File: rtl/l2_request_arbiter.sv
// Shares the unified L2 port between the L1I miss path and the L1D
// miss/writeback path. A granted command is latched and held on the L2 port
// until resp_l2, and the L2 response is passed straight back to its owner.
module l2_request_arbiter
  import cache_types_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int LINE_WIDTH = LINE_W,
  parameter bit FAIR       = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_I,
  input  logic [ADDR_WIDTH-1:0] address_I,
  output logic [LINE_WIDTH-1:0] rdata_I,
  output logic                  resp_I,
  input  logic                  read_D,
  input  logic                  write_D,
  input  logic [ADDR_WIDTH-1:0] address_D,
  input  logic [LINE_WIDTH-1:0] wdata_D,
  output logic [LINE_WIDTH-1:0] rdata_D,
  output logic                  resp_D,
  output logic                  read_l2,
  output logic                  write_l2,
  output logic [ADDR_WIDTH-1:0] address_l2,
  output logic [LINE_WIDTH-1:0] wdata_l2,
  input  logic [LINE_WIDTH-1:0] rdata_l2,
  input  logic                  resp_l2,
  output logic                  id_conflict
);

  arb_state_t state;
  arb_state_t state_next;

  logic                  cmd_rd;
  logic                  cmd_wr;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LINE_WIDTH-1:0] cmd_wdata;
  logic                  last_grant;

  logic arb_enable;
  logic req_i;
  logic req_d;
  logic grant_i;
  logic grant_d;
  logic conflict;

  // Arbitration only happens in IDLE, so requests seen mid-grant or during
  // reset never produce a grant or a conflict pulse.
  assign arb_enable = (state == IDLE) & ~reset;
  assign req_i      = read_I & arb_enable;
  assign req_d      = (read_D | write_D) & arb_enable;

  arb_priority_select #(
    .FAIR (FAIR)
  ) u_select (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_grant (last_grant),
    .grant_i    (grant_i),
    .grant_d    (grant_d),
    .conflict   (conflict)
  );

  assign id_conflict = conflict;

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the winning command on a grant so the L2 port never follows live inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_rd     <= 1'b0;
      cmd_wr     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      last_grant <= LAST_I;
    end else if (grant_d) begin
      cmd_rd     <= ~write_D;
      cmd_wr     <= write_D;
      cmd_addr   <= address_D;
      cmd_wdata  <= write_D ? wdata_D : '0;
      last_grant <= LAST_D;
    end else if (grant_i) begin
      cmd_rd     <= 1'b1;
      cmd_wr     <= 1'b0;
      cmd_addr   <= address_I;
      cmd_wdata  <= '0;
      last_grant <= LAST_I;
    end
  end

  // Next-state logic, L2 command drive and response routing back to the owner.
  always_comb begin
    state_next = state;
    read_l2    = 1'b0;
    write_l2   = 1'b0;
    address_l2 = '0;
    wdata_l2   = '0;
    resp_I     = 1'b0;
    resp_D     = 1'b0;
    rdata_I    = '0;
    rdata_D    = '0;

    case (state)
      IDLE: begin
        if (grant_d) begin
          state_next = GRANT_D;
        end else if (grant_i) begin
          state_next = GRANT_I;
        end
      end

      GRANT_I: begin
        read_l2    = cmd_rd;
        write_l2   = cmd_wr;
        address_l2 = cmd_addr;
        wdata_l2   = cmd_wdata;
        if (resp_l2) begin
          resp_I     = 1'b1;
          rdata_I    = rdata_l2;
          state_next = IDLE;
        end
      end

      GRANT_D: begin
        read_l2    = cmd_rd;
        write_l2   = cmd_wr;
        address_l2 = cmd_addr;
        wdata_l2   = cmd_wdata;
        if (resp_l2) begin
          resp_D     = 1'b1;
          rdata_D    = rdata_l2;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (reset) begin
      read_l2    = 1'b0;
      write_l2   = 1'b0;
      address_l2 = '0;
      wdata_l2   = '0;
      resp_I     = 1'b0;
      resp_D     = 1'b0;
      rdata_I    = '0;
      rdata_D    = '0;
    end
  end

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Self-checking bench for l2_request_arbiter: one FAIR=1 and one FAIR=0 instance,
// directed scenarios followed by random requester/L2 traffic against a
// transaction-level model of who owns the L2 port.
module tb_l2_request_arbiter;

  logic clk;
  logic reset;

  logic         read_I     [2];
  logic [31:0]  address_I  [2];
  logic [255:0] rdata_I    [2];
  logic         resp_I     [2];
  logic         read_D     [2];
  logic         write_D    [2];
  logic [31:0]  address_D  [2];
  logic [255:0] wdata_D    [2];
  logic [255:0] rdata_D    [2];
  logic         resp_D     [2];
  logic         read_l2    [2];
  logic         write_l2   [2];
  logic [31:0]  address_l2 [2];
  logic [255:0] wdata_l2   [2];
  logic [255:0] rdata_l2   [2];
  logic         resp_l2    [2];
  logic         id_conflict[2];

  // Model: owner 0 = port free, 1 = L1I transaction, 2 = L1D transaction.
  int           owner   [2];
  bit           last_d  [2];
  bit           m_rd    [2];
  bit           m_wr    [2];
  logic [31:0]  m_addr  [2];
  logic [255:0] m_wdata [2];
  int           delay   [2];
  bit           drop_i  [2];
  bit           drop_d  [2];

  int checks;
  int failures;

  l2_request_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256), .FAIR(1'b1)) dut_fair (
    .clk(clk), .reset(reset),
    .read_I(read_I[0]), .address_I(address_I[0]), .rdata_I(rdata_I[0]), .resp_I(resp_I[0]),
    .read_D(read_D[0]), .write_D(write_D[0]), .address_D(address_D[0]), .wdata_D(wdata_D[0]),
    .rdata_D(rdata_D[0]), .resp_D(resp_D[0]),
    .read_l2(read_l2[0]), .write_l2(write_l2[0]), .address_l2(address_l2[0]), .wdata_l2(wdata_l2[0]),
    .rdata_l2(rdata_l2[0]), .resp_l2(resp_l2[0]), .id_conflict(id_conflict[0])
  );

  l2_request_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256), .FAIR(1'b0)) dut_fixed (
    .clk(clk), .reset(reset),
    .read_I(read_I[1]), .address_I(address_I[1]), .rdata_I(rdata_I[1]), .resp_I(resp_I[1]),
    .read_D(read_D[1]), .write_D(write_D[1]), .address_D(address_D[1]), .wdata_D(wdata_D[1]),
    .rdata_D(rdata_D[1]), .resp_D(resp_D[1]),
    .read_l2(read_l2[1]), .write_l2(write_l2[1]), .address_l2(address_l2[1]), .wdata_l2(wdata_l2[1]),
    .rdata_l2(rdata_l2[1]), .resp_l2(resp_l2[1]), .id_conflict(id_conflict[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic checkValue(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output of instance k against what the model says this cycle should show.
  task automatic checkOutput(input int k);
    logic [255:0] e_rd, e_wr, e_addr, e_wdata, e_ri, e_rdi, e_rd_resp, e_rdd, e_conf;
    string p;
    p = (k == 0) ? "fair" : "fixed";
    e_rd = '0; e_wr = '0; e_addr = '0; e_wdata = '0;
    e_ri = '0; e_rdi = '0; e_rd_resp = '0; e_rdd = '0; e_conf = '0;
    if (owner[k] == 0) begin
      e_conf = 256'(read_I[k] & (read_D[k] | write_D[k]));
    end else if (owner[k] == 1) begin
      e_rd   = 256'(1);
      e_addr = 256'(m_addr[k]);
      if (resp_l2[k]) begin
        e_ri  = 256'(1);
        e_rdi = rdata_l2[k];
      end
    end else begin
      e_rd    = 256'(m_rd[k]);
      e_wr    = 256'(m_wr[k]);
      e_addr  = 256'(m_addr[k]);
      e_wdata = m_wr[k] ? m_wdata[k] : '0;
      if (resp_l2[k]) begin
        e_rd_resp = 256'(1);
        e_rdd     = rdata_l2[k];
      end
    end
    checkValue({p, ".read_l2"},     256'(read_l2[k]),     e_rd);
    checkValue({p, ".write_l2"},    256'(write_l2[k]),    e_wr);
    checkValue({p, ".address_l2"},  256'(address_l2[k]),  e_addr);
    checkValue({p, ".wdata_l2"},    wdata_l2[k],          e_wdata);
    checkValue({p, ".resp_I"},      256'(resp_I[k]),      e_ri);
    checkValue({p, ".rdata_I"},     rdata_I[k],           e_rdi);
    checkValue({p, ".resp_D"},      256'(resp_D[k]),      e_rd_resp);
    checkValue({p, ".rdata_D"},     rdata_D[k],           e_rdd);
    checkValue({p, ".id_conflict"}, 256'(id_conflict[k]), e_conf);
  endtask

  // Advance the ownership model across one clock edge using that cycle's inputs.
  task automatic modelUpdate(input int k);
    bit want_i, want_d, d_wins;
    if (reset) begin
      owner[k]  = 0;
      last_d[k] = 1'b0;
      return;
    end
    if (owner[k] != 0) begin
      if (resp_l2[k]) begin
        if (owner[k] == 1) drop_i[k] = 1'b1;
        else               drop_d[k] = 1'b1;
        owner[k] = 0;
      end
      return;
    end
    want_i = read_I[k];
    want_d = read_D[k] | write_D[k];
    if (!want_i && !want_d) return;
    if (want_i && want_d) d_wins = (k == 0) ? !last_d[k] : 1'b1;
    else                  d_wins = want_d;
    if (d_wins) begin
      owner[k]   = 2;
      last_d[k]  = 1'b1;
      m_addr[k]  = address_D[k];
      m_wr[k]    = write_D[k];
      m_rd[k]    = !write_D[k];
      m_wdata[k] = write_D[k] ? wdata_D[k] : '0;
    end else begin
      owner[k]  = 1;
      last_d[k] = 1'b0;
      m_addr[k] = address_I[k];
    end
    delay[k] = $urandom_range(0, 3);
  endtask

  // One clock cycle: check mid-cycle, cross the edge, update the model, return at negedge.
  task automatic step();
    #2;
    if (!reset) begin
      for (int k = 0; k < 2; k++) checkOutput(k);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) modelUpdate(k);
    @(negedge clk);
  endtask

  // Random requester and L2 behaviour for one cycle, driven from the model's view of ownership.
  task automatic applyStimulus();
    reset = ($urandom_range(0, 99) == 0);
    for (int k = 0; k < 2; k++) begin
      rdata_l2[k] = rand256();
      if (owner[k] != 0) begin
        if (delay[k] == 0) begin
          resp_l2[k] = 1'b1;
        end else begin
          resp_l2[k] = 1'b0;
          delay[k]--;
        end
      end else begin
        resp_l2[k] = ($urandom_range(0, 7) == 0);
      end

      if (drop_i[k]) begin
        read_I[k] = 1'b0;
        drop_i[k] = 1'b0;
      end else if (!read_I[k]) begin
        if ($urandom_range(0, 2) == 0) begin
          read_I[k]    = 1'b1;
          address_I[k] = {$urandom_range(0, 32'h07FF_FFFF), 5'b0};
        end
      end else if (owner[k] == 1) begin
        if ($urandom_range(0, 1) == 0) address_I[k] = $urandom;
        if ($urandom_range(0, 7) == 0) read_I[k] = 1'b0;
      end

      if (drop_d[k]) begin
        read_D[k]  = 1'b0;
        write_D[k] = 1'b0;
        drop_d[k]  = 1'b0;
      end else if (!(read_D[k] | write_D[k])) begin
        if ($urandom_range(0, 2) == 0) begin
          int kind;
          kind         = $urandom_range(0, 2);
          read_D[k]    = (kind != 1);
          write_D[k]   = (kind != 0);
          address_D[k] = {$urandom_range(0, 32'h07FF_FFFF), 5'b0};
          wdata_D[k]   = rand256();
        end
      end else if (owner[k] == 2) begin
        if ($urandom_range(0, 1) == 0) address_D[k] = $urandom;
        if ($urandom_range(0, 1) == 0) wdata_D[k] = rand256();
      end
    end
  endtask

  task automatic clearInputs();
    for (int k = 0; k < 2; k++) begin
      read_I[k] = 1'b0; address_I[k] = '0;
      read_D[k] = 1'b0; write_D[k] = 1'b0; address_D[k] = '0; wdata_D[k] = '0;
      rdata_l2[k] = '0; resp_l2[k] = 1'b0;
      drop_i[k] = 1'b0; drop_d[k] = 1'b0;
      owner[k] = 0; last_d[k] = 1'b0; delay[k] = 0;
      m_rd[k] = 1'b0; m_wr[k] = 1'b0; m_addr[k] = '0; m_wdata[k] = '0;
    end
  endtask

  initial begin
    logic [255:0] pat_a5;
    logic [255:0] pat_wd;
    checks   = 0;
    failures = 0;
    pat_a5   = {32{8'hA5}};
    pat_wd   = {8{32'hDEAD_0001}};
    clearInputs();
    reset = 1'b1;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;

    // Reset state: port quiet on both instances.
    #1;
    checkValue("reset.read_l2",  256'(read_l2[0]),  256'(0));
    checkValue("reset.write_l2", 256'(write_l2[1]), 256'(0));
    step();

    // Sole L1I read, L2 answers three cycles after the strobe appears.
    read_I[0] = 1'b1; address_I[0] = 32'h0000_0040;
    #1;
    checkValue("soleI.no_strobe_yet", 256'(read_l2[0]), 256'(0));
    step();
    for (int c = 0; c < 3; c++) begin
      #1;
      checkValue("soleI.read_l2",    256'(read_l2[0]),    256'(1));
      checkValue("soleI.address_l2", 256'(address_l2[0]), 256'(32'h40));
      step();
    end
    resp_l2[0] = 1'b1; rdata_l2[0] = pat_a5;
    #1;
    checkValue("soleI.resp_I",  256'(resp_I[0]), 256'(1));
    checkValue("soleI.rdata_I", rdata_I[0],       pat_a5);
    checkValue("soleI.resp_D",  256'(resp_D[0]),  256'(0));
    step();
    resp_l2[0] = 1'b0; rdata_l2[0] = '0; read_I[0] = 1'b0; drop_i[0] = 1'b0;
    step();

    // Simultaneous I read and D read+write on both instances: D first, write wins.
    for (int k = 0; k < 2; k++) begin
      read_I[k] = 1'b1; address_I[k] = 32'h0000_0080;
      read_D[k] = 1'b1; write_D[k] = 1'b1; address_D[k] = 32'h0000_0100; wdata_D[k] = pat_wd;
    end
    #1;
    checkValue("conf1.id_conflict_fair",  256'(id_conflict[0]), 256'(1));
    checkValue("conf1.id_conflict_fixed", 256'(id_conflict[1]), 256'(1));
    step();
    for (int k = 0; k < 2; k++) begin
      address_D[k] = 32'h0000_0200;
      resp_l2[k]   = 1'b1;
      rdata_l2[k]  = pat_a5;
    end
    #1;
    checkValue("conf1.write_l2",   256'(write_l2[0]),   256'(1));
    checkValue("conf1.read_l2",    256'(read_l2[0]),    256'(0));
    checkValue("conf1.wdata_l2",   wdata_l2[0],         pat_wd);
    checkValue("conf1.address_l2", 256'(address_l2[1]), 256'(32'h100));
    checkValue("conf1.resp_D",     256'(resp_D[0]),     256'(1));
    step();
    for (int k = 0; k < 2; k++) begin
      read_D[k] = 1'b0; write_D[k] = 1'b0; drop_d[k] = 1'b0; resp_l2[k] = 1'b0;
    end
    #1;
    checkValue("conf1.dead_cycle", 256'(read_l2[0]), 256'(0));
    step();
    for (int k = 0; k < 2; k++) resp_l2[k] = 1'b1;
    #1;
    checkValue("conf1.then_I", 256'(resp_I[0]), 256'(1));
    step();
    for (int k = 0; k < 2; k++) begin
      resp_l2[k] = 1'b0; drop_i[k] = 1'b0;
      read_I[k] = 1'b1; read_D[k] = 1'b1; address_D[k] = 32'h0000_0300;
    end
    #1;
    checkValue("conf2.id_conflict", 256'(id_conflict[0]), 256'(1));
    step();
    #1;
    checkValue("conf2.D_after_I", 256'(read_l2[0]), 256'(1));
    checkValue("conf2.D_addr",    256'(address_l2[0]), 256'(32'h300));
    step();

    // Reset in the middle of a grant, then a late L2 response that must be dropped.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      read_I[k] = 1'b0; read_D[k] = 1'b0; resp_l2[k] = 1'b1; rdata_l2[k] = pat_a5;
    end
    #1;
    checkValue("rst.read_l2", 256'(read_l2[0]), 256'(0));
    checkValue("rst.resp_I",  256'(resp_I[0]),  256'(0));
    checkValue("rst.resp_D",  256'(resp_D[1]),  256'(0));
    step();
    clearInputs();
    step();

    // Random traffic against the ownership model.
    for (int c = 0; c < 4000; c++) begin
      applyStimulus();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
